// File: rtl/led_status_latch_pkg.sv
// Shared constants for the LED status latch: channel count, counter width, FSM encoding.
package led_status_latch_pkg;

    localparam int NUM_CH = 6;
    localparam int CNT_W  = 8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARM      = 2'd1;
    localparam logic [1:0] ST_MAINT    = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    function automatic logic [3:0] ones(input logic [NUM_CH-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/led_status_latch_sync.sv
// Two-flop synchroniser plus a history flop; level is the synced value, rise its 0->1 edge.
// Latency: 2 cycles to level, rise valid in the same cycle as the new level.
module sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             slow_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev;

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~prev;

endmodule

// File: rtl/led_status_latch.sv
// Latches synced status rising edges until acknowledged, counts events, runs the maintenance FSM.
// Latency: raw edge at clock N appears on outputs after edge N+2; no backpressure.
// Optional LED_STATUS_AUTOCLR_EN: latches self-clear after AUTOCLR_CYCLES low cycles.
module led_status_latch
    import led_status_latch_pkg::*;
#(
    parameter int MTNE_HOLD      = 4,
    parameter int MTNE_TIMEOUT   = 50,
    parameter int AUTOCLR_CYCLES = 20
) (
    input  logic              slow_clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] status_in,
    input  logic              ack_btn,
    input  logic              mtne_req,
    output logic [NUM_CH-1:0] led_enable,
    output logic              mtne_mode,
    output logic [CNT_W-1:0]  event_count
);

    localparam logic [7:0]  HOLD_V    = 8'(MTNE_HOLD);
    localparam logic [15:0] TIMEOUT_V = 16'(MTNE_TIMEOUT);

    logic [NUM_CH-1:0] s2_status, rise_status;
    logic              s2_ack, rise_ack;
    logic              s2_mtne, rise_mtne;

    sync_edge #(.WIDTH(NUM_CH)) u_sync_status (
        .slow_clock (slow_clock), .reset (reset), .raw (status_in),
        .level (s2_status), .rise (rise_status)
    );
    sync_edge #(.WIDTH(1)) u_sync_ack (
        .slow_clock (slow_clock), .reset (reset), .raw (ack_btn),
        .level (s2_ack), .rise (rise_ack)
    );
    sync_edge #(.WIDTH(1)) u_sync_mtne (
        .slow_clock (slow_clock), .reset (reset), .raw (mtne_req),
        .level (s2_mtne), .rise (rise_mtne)
    );

    logic [1:0]        state, state_next;
    logic [7:0]        hold_cnt, hold_cnt_next;
    logic [15:0]       timer, timer_next;
    logic [NUM_CH-1:0] ack_clr, auto_clr, latch_next;
    logic [CNT_W:0]    count_sum;

    // Inside MAINT the ack button is consumed as the exit request only.
    assign ack_clr    = (rise_ack && state != ST_MAINT) ? ~s2_status : '0;
    assign latch_next = (led_enable & ~(ack_clr | auto_clr)) | rise_status;
    assign count_sum  = {1'b0, event_count} + (CNT_W+1)'(ones(rise_status));

`ifdef LED_STATUS_AUTOCLR_EN
    localparam logic [7:0] AUTOCLR_V = 8'(AUTOCLR_CYCLES);
    logic [7:0] low_cnt [NUM_CH];

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) low_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s2_status[i] || !led_enable[i]) low_cnt[i] <= '0;
                else if (low_cnt[i] != AUTOCLR_V)   low_cnt[i] <= low_cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        auto_clr = '0;
        for (int i = 0; i < NUM_CH; i++) auto_clr[i] = (low_cnt[i] == AUTOCLR_V);
    end
`else
    assign auto_clr = '0;
`endif

    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        timer_next    = timer;
        case (state)
            ST_IDLE: begin
                if (s2_mtne) begin
                    state_next    = ST_ARM;
                    hold_cnt_next = 8'd1;
                end
            end
            ST_ARM: begin
                if (!s2_mtne) begin
                    state_next = ST_IDLE;
                end else if (hold_cnt == HOLD_V) begin
                    state_next = ST_MAINT;
                    timer_next = TIMEOUT_V;
                end else begin
                    hold_cnt_next = hold_cnt + 8'd1;
                end
            end
            ST_MAINT: begin
                if (timer == 16'd1 || rise_ack) state_next = ST_WAIT_REL;
                else                            timer_next = timer - 16'd1;
            end
            default: begin
                if (!s2_mtne) state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            timer       <= '0;
            led_enable  <= '0;
            mtne_mode   <= 1'b0;
            event_count <= '0;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            timer       <= timer_next;
            led_enable  <= latch_next;
            mtne_mode   <= (state_next == ST_MAINT);
            event_count <= count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0];
        end
    end

    logic unused_ok;
    assign unused_ok = s2_ack ^ rise_mtne;

endmodule

// File: tb/tb_led_status_latch.sv
// Directed bench for led_status_latch: table of latch/ack vectors plus hand-written FSM, reset,
// saturation and auto-clear sequences.
module tb_led_status_latch;

    logic       slow_clock = 1'b0;
    logic       clk_run    = 1'b1;
    logic       reset;
    logic [5:0] status_in;
    logic       ack_btn;
    logic       mtne_req;
    logic [5:0] led_enable;
    logic       mtne_mode;
    logic [7:0] event_count;

    int total = 0;
    int bad   = 0;

    led_status_latch dut (
        .slow_clock  (slow_clock),
        .reset       (reset),
        .status_in   (status_in),
        .ack_btn     (ack_btn),
        .mtne_req    (mtne_req),
        .led_enable  (led_enable),
        .mtne_mode   (mtne_mode),
        .event_count (event_count)
    );

    always #5 if (clk_run) slow_clock = ~slow_clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge slow_clock);
        #1;
    endtask

    typedef struct {
        logic [5:0] status;
        logic       ack;
        int         ncyc;
        logic [5:0] exp_led;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int first_hi, hi_cnt, reentry;
        logic seen_drop, last_mode;

        tbl[0]  = '{6'b000101, 1'b0, 1, 6'b000000, 8'd0};
        tbl[1]  = '{6'b000100, 1'b0, 1, 6'b000000, 8'd0};
        tbl[2]  = '{6'b000100, 1'b0, 1, 6'b000101, 8'd2};
        tbl[3]  = '{6'b000100, 1'b1, 2, 6'b000101, 8'd2};
        tbl[4]  = '{6'b000100, 1'b1, 1, 6'b000100, 8'd2};
        tbl[5]  = '{6'b000000, 1'b0, 3, 6'b000100, 8'd2};
        tbl[6]  = '{6'b000000, 1'b1, 3, 6'b000000, 8'd2};
        tbl[7]  = '{6'b000000, 1'b0, 3, 6'b000000, 8'd2};
        tbl[8]  = '{6'b001000, 1'b1, 3, 6'b001000, 8'd3};
        tbl[9]  = '{6'b000000, 1'b0, 3, 6'b001000, 8'd3};
        tbl[10] = '{6'b000000, 1'b1, 3, 6'b000000, 8'd3};
        tbl[11] = '{6'b000000, 1'b0, 3, 6'b000000, 8'd3};

        reset = 1'b0; status_in = '0; ack_btn = 1'b0; mtne_req = 1'b0;
        #12;
        chk("reset_led", 32'(led_enable), 32'd0);
        chk("reset_mode", 32'(mtne_mode), 32'd0);
        chk("reset_cnt", 32'(event_count), 32'd0);
        @(negedge slow_clock);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 12; i++) begin
            status_in = tbl[i].status;
            ack_btn   = tbl[i].ack;
            step(tbl[i].ncyc);
            chk($sformatf("vec%0d_led", i), 32'(led_enable), 32'(tbl[i].exp_led));
            chk($sformatf("vec%0d_cnt", i), 32'(event_count), 32'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d_mode", i), 32'(mtne_mode), 32'd0);
        end

        // Maintenance entry and timeout with the switch held throughout.
        mtne_req = 1'b1;
        first_hi = 0; hi_cnt = 0; reentry = 0; seen_drop = 1'b0; last_mode = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            step(1);
            if (mtne_mode && first_hi == 0) first_hi = i;
            if (mtne_mode) hi_cnt++;
            if (!mtne_mode && last_mode) seen_drop = 1'b1;
            if (mtne_mode && !last_mode && seen_drop) reentry++;
            last_mode = mtne_mode;
        end
        chk("mtne_first_edge", 32'(first_hi), 32'd7);
        chk("mtne_high_cycles", 32'(hi_cnt), 32'd50);
        chk("mtne_no_reentry", 32'(reentry), 32'd0);
        mtne_req = 1'b0;
        step(4);

        // Second run: latches set, ack during MAINT exits without clearing them.
        status_in = 6'b000111;
        step(1);
        status_in = '0;
        step(2);
        chk("run2_led_set", 32'(led_enable), 32'b000111);
        chk("run2_cnt", 32'(event_count), 32'd6);
        mtne_req = 1'b1;
        step(6);
        chk("run2_mode_pre", 32'(mtne_mode), 32'd0);
        step(1);
        chk("run2_mode_on", 32'(mtne_mode), 32'd1);
        step(10);
        ack_btn = 1'b1;
        step(2);
        chk("run2_mode_ack_sync", 32'(mtne_mode), 32'd1);
        step(1);
        chk("run2_mode_ack_exit", 32'(mtne_mode), 32'd0);
        chk("run2_led_kept", 32'(led_enable), 32'b000111);
        ack_btn = 1'b0;
        step(5);
        chk("run2_wait_rel", 32'(mtne_mode), 32'd0);
        mtne_req = 1'b0;
        step(4);

        // Third run: reset while in MAINT with the clock stopped.
        mtne_req = 1'b1;
        step(7);
        chk("run3_mode_on", 32'(mtne_mode), 32'd1);
        chk("run3_led_set", 32'(led_enable), 32'b000111);
        @(negedge slow_clock);
        clk_run = 1'b0;
        #3;
        reset    = 1'b0;
        mtne_req = 1'b0;
        #2;
        chk("async_rst_led", 32'(led_enable), 32'd0);
        chk("async_rst_mode", 32'(mtne_mode), 32'd0);
        chk("async_rst_cnt", 32'(event_count), 32'd0);
        #3;
        reset   = 1'b1;
        clk_run = 1'b1;
        step(3);
        chk("post_rst_led", 32'(led_enable), 32'd0);

        // Saturation of the event counter.
        for (int i = 0; i < 127; i++) begin
            status_in = 6'b000011; step(1);
            status_in = '0;        step(1);
        end
        step(3);
        chk("sat_254", 32'(event_count), 32'd254);
        for (int i = 0; i < 3; i++) begin
            status_in = 6'b000011; step(1);
            status_in = '0;        step(1);
        end
        step(3);
        chk("sat_255", 32'(event_count), 32'd255);
        status_in = 6'b000011; step(1);
        status_in = '0;        step(4);
        chk("sat_hold", 32'(event_count), 32'd255);

        ack_btn = 1'b1;
        step(3);
        chk("ack_clear_all", 32'(led_enable), 32'd0);
        ack_btn = 1'b0;
        step(3);

        // Auto-clear window on channel 0.
        status_in = 6'b000001;
        step(1);
        status_in = '0;
        step(2);
        chk("auto_led_set", 32'(led_enable), 32'd1);
        step(20);
        chk("auto_before", 32'(led_enable), 32'd1);
        step(1);
`ifdef LED_STATUS_AUTOCLR_EN
        chk("auto_cleared", 32'(led_enable), 32'd0);
`else
        chk("auto_kept", 32'(led_enable), 32'd1);
`endif
        step(10);
`ifdef LED_STATUS_AUTOCLR_EN
        chk("auto_stays_clear", 32'(led_enable), 32'd0);
`else
        chk("auto_stays_set", 32'(led_enable), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
